// File: rtl/spi_slave_ctrl_gen.sv
// SPI slave transaction controller: header decode, single/burst read and write sequencing, abort detection.
// Optional write protection is compiled in with SPI_CTRL_WRITE_PROTECT_EN.
module spi_slave_ctrl_gen #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 4
) (
  input  logic             sclk_pin,
  input  logic             reset_counter,
  input  logic             cs_pin,
  input  logic             rw,
  input  logic             burst_en,
`ifdef SPI_CTRL_WRITE_PROTECT_EN
  input  logic             wp_pin,
  output logic             wp_err,
`endif
  output logic             shift_wren,
  output logic             addr_wren,
  output logic             addr_inc,
  output logic             dm_wren,
  output logic             miso_en,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             busy,
  output logic             frame_err
);

  localparam int unsigned HDR_LEN = ADDR_W + 1;
  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_LEN - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_HEADER, S_DECODE, S_RD_LOAD, S_RD_SHIFT,
    S_RD_INC, S_WR_SHIFT, S_WR_COMMIT, S_DONE
  } state_t;

  state_t state;
  logic   wr_burst;
  logic   abort_err_c;

  // Deselect counts as an abort only when a frame is genuinely in flight.
  always_comb begin
    abort_err_c = 1'b0;
    case (state)
      S_HEADER:    abort_err_c = (bit_cnt != '0);
      S_DECODE,
      S_RD_LOAD,
      S_RD_SHIFT,
      S_WR_SHIFT,
      S_WR_COMMIT: abort_err_c = 1'b1;
      default:     abort_err_c = 1'b0;
    endcase
  end

  // Outputs are registered with the value belonging to the state being entered.
  always_ff @(posedge sclk_pin or posedge reset_counter) begin
    if (reset_counter) begin
      state      <= S_HEADER;
      bit_cnt    <= '0;
      wr_burst   <= 1'b0;
      shift_wren <= 1'b0;
      addr_wren  <= 1'b0;
      addr_inc   <= 1'b0;
      dm_wren    <= 1'b0;
      miso_en    <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
`ifdef SPI_CTRL_WRITE_PROTECT_EN
      wp_err     <= 1'b0;
`endif
    end else begin
      shift_wren <= 1'b0;
      addr_wren  <= 1'b0;
      addr_inc   <= 1'b0;
      dm_wren    <= 1'b0;
      miso_en    <= 1'b0;
      busy       <= 1'b1;
      if (cs_pin) begin
        state   <= S_HEADER;
        bit_cnt <= '0;
        busy    <= 1'b0;
        if (abort_err_c) frame_err <= 1'b1;
      end else begin
        case (state)
          S_HEADER: begin
            if (bit_cnt == '0) begin
              frame_err <= 1'b0;
`ifdef SPI_CTRL_WRITE_PROTECT_EN
              wp_err    <= 1'b0;
`endif
            end
            if (bit_cnt == HDR_LAST) begin
              state     <= S_DECODE;
              bit_cnt   <= '0;
              addr_wren <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_DECODE: begin
            if (rw) begin
              state      <= S_RD_LOAD;
              shift_wren <= 1'b1;
              miso_en    <= 1'b1;
            end else begin
              state <= S_WR_SHIFT;
            end
          end
          S_RD_LOAD: begin
            state   <= S_RD_SHIFT;
            miso_en <= 1'b1;
          end
          S_RD_SHIFT: begin
            if (bit_cnt == DAT_LAST) begin
              bit_cnt <= '0;
              if (burst_en) begin
                state    <= S_RD_INC;
                addr_inc <= 1'b1;
                miso_en  <= 1'b1;
              end else begin
                state <= S_DONE;
                busy  <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
              miso_en <= 1'b1;
            end
          end
          S_RD_INC: begin
            state      <= S_RD_LOAD;
            shift_wren <= 1'b1;
            miso_en    <= 1'b1;
          end
          S_WR_SHIFT: begin
            if (bit_cnt == DAT_LAST) begin
              state    <= S_WR_COMMIT;
              bit_cnt  <= '0;
              addr_inc <= burst_en;
              wr_burst <= burst_en;
`ifdef SPI_CTRL_WRITE_PROTECT_EN
              dm_wren  <= ~wp_pin;
              if (wp_pin) wp_err <= 1'b1;
`else
              dm_wren  <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          S_WR_COMMIT: begin
            if (wr_burst) begin
              state <= S_WR_SHIFT;
            end else begin
              state <= S_DONE;
              busy  <= 1'b0;
            end
          end
          S_DONE: begin
            busy <= 1'b0;
          end
          default: begin
            state   <= S_HEADER;
            bit_cnt <= '0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
